io_port_unit: RTL

Services the processor's IN, OUT and HLT instructions, the consumer side of the control unit's `WriteSrc`/`OutWrite`/`HLT` outputs. Holds the pipeline with `stall` while an IN waits for the operator to set switches and press a debounced confirm button. Latches OUT operands into a display register. Freezes the core permanently on HLT. Sits between the control/datapath and the board I/O (switches, button, 7-segment driver).

---
 rtl/io_pkg.sv | 15 +
 rtl/button_debounce.sv | 50 +++++
 rtl/io_port_unit.sv | 84 ++++++++
 3 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared state encoding and default widths for the IN/OUT/HLT port unit
package io_pkg;

    localparam int DATA_W = 32;
    localparam int SW_W   = 16;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_PRESS   = 3'd1,
        WAIT_RELEASE = 3'd2,
        DONE         = 3'd3,
        HALTED       = 3'd4
    } io_state_t;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - confirm-button synchronizer and debouncer; counter enabled by IO_DEBOUNCE_EN
module button_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic confirm_btn,
    output logic btn_db
);

    logic sync1;
    logic btn_s;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= confirm_btn;
            btn_s <= sync1;
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [CW-1:0] cnt;
    logic          db_q;

    // Any return to agreement restarts the count, so short glitches never toggle db_q.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            db_q <= 1'b0;
        end else if (btn_s == db_q) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
            db_q <= ~db_q;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign btn_db = db_q;
`else
    assign btn_db = btn_s;
`endif

endmodule

// File: rtl/io_port_unit.sv
// rtl/io_port_unit.sv - IN/OUT/HLT servicing with operator handshake; debounce via IO_DEBOUNCE_EN
module io_port_unit #(
    parameter int DATA_W       = io_pkg::DATA_W,
    parameter int SW_W         = io_pkg::SW_W,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_req,
    input  logic              out_req,
    input  logic              hlt,
    input  logic [DATA_W-1:0] out_data,
    input  logic [SW_W-1:0]   switches,
    input  logic              confirm_btn,
    output logic [DATA_W-1:0] in_data,
    output logic              in_valid,
    output logic              stall,
    output logic [DATA_W-1:0] display,
    output logic              waiting,
    output logic              halted
);

    import io_pkg::*;

    io_state_t state;
    logic      btn_db;
    logic      stall_hold;

    button_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clock       (clock),
        .reset_n     (reset_n),
        .confirm_btn (confirm_btn),
        .btn_db      (btn_db)
    );

    assign stall_hold = (state == WAIT_PRESS) || (state == WAIT_RELEASE) || (state == HALTED);

    // The request terms cover the issue cycle so the PC never slips past IN or HLT.
    assign stall    = stall_hold || hlt || ((state == IDLE) && in_req);
    assign in_valid = (state == DONE) && !hlt;
    assign waiting  = (state == WAIT_PRESS);
    assign halted   = (state == HALTED);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            in_data <= '0;
            display <= '0;
        end else begin
            // A simultaneous IN in IDLE raises stall but must not block the OUT.
            if (out_req && !stall_hold && !hlt) begin
                display <= out_data;
            end
            if (hlt) begin
                state <= HALTED;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_req) begin
                            state <= WAIT_PRESS;
                        end
                    end
                    WAIT_PRESS: begin
                        if (btn_db) begin
                            in_data <= DATA_W'(switches);
                            state   <= WAIT_RELEASE;
                        end
                    end
                    WAIT_RELEASE: begin
                        if (!btn_db) begin
                            state <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    HALTED:  state <= HALTED;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
